// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, instruction constants and IF-stage state encoding
package pipeline_pkg;
   localparam int NB_WORD    = 32;
   localparam int NB_OPCODE  = 6;
   localparam int NB_REG     = 5;
   localparam int NB_SHAMT   = 5;
   localparam int NB_FUNCT   = 6;
   localparam int NB_IMM     = 16;
   localparam int NB_JADDR   = 26;
   localparam logic [NB_WORD-1:0]   INSTR_NOP     = 32'h0000_0000;
   localparam logic [NB_WORD-1:0]   INSTR_HALT    = 32'hFFFF_FFFF;
   localparam logic [NB_OPCODE-1:0] OPCODE_TIPO_R = 6'b000000;
   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} fetch_state_t;
endpackage

// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed program store, sync write port, async read port
module instruction_memory #(
   parameter int NB_WORD      = 32,
   parameter int NB_IMEM_ADDR = 8
) (
   input  logic                    i_clk,
   input  logic                    i_we,
   input  logic [NB_IMEM_ADDR-1:0] i_waddr,
   input  logic [NB_WORD-1:0]      i_wdata,
   input  logic [NB_IMEM_ADDR-1:0] i_raddr,
   output logic [NB_WORD-1:0]      o_rdata
);
   logic [NB_WORD-1:0] r_mem [2**NB_IMEM_ADDR];
   // debug loader write; array has no reset so programs survive a pipeline reset
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, instruction memory, IF/ID register and halt FSM
module instruction_fetch #(
   parameter int NB_WORD      = pipeline_pkg::NB_WORD,
   parameter int NB_IMEM_ADDR = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_stall,
   input  logic                    i_jump,
   input  logic [NB_WORD-1:0]      i_jump_addr,
   input  logic                    i_imem_we,
   input  logic [NB_IMEM_ADDR-1:0] i_imem_waddr,
   input  logic [NB_WORD-1:0]      i_imem_wdata,
   output logic [NB_WORD-1:0]      o_pc,
   output logic [NB_WORD-1:0]      o_pc4,
   output logic [NB_WORD-1:0]      o_instruction,
   output logic                    o_halt
);
   import pipeline_pkg::*;
   fetch_state_t       r_state, w_state_next;
   logic [NB_WORD-1:0] r_pc, r_pc4, r_instr;
   logic [NB_WORD-1:0] w_pc_next, w_pc4_next, w_instr_next, w_fetch, w_pc_plus4, w_jump_target;
   instruction_memory #(.NB_WORD(NB_WORD), .NB_IMEM_ADDR(NB_IMEM_ADDR)) u_imem (
      .i_clk   (i_clk),
      .i_we    (i_imem_we),
      .i_waddr (i_imem_waddr),
      .i_wdata (i_imem_wdata),
      .i_raddr (r_pc[NB_IMEM_ADDR+1:2]),
      .o_rdata (w_fetch)
   );
   assign w_pc_plus4    = r_pc + NB_WORD'(4);
   assign w_jump_target = i_jump_addr & ~NB_WORD'(3);
   // halt state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_RUN;
      else         r_state <= w_state_next;
   end
   // priority mux: enable > halted > jump flush > stall > normal fetch
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_pc4_next   = r_pc4;
      w_instr_next = r_instr;
      if (i_enable) begin
         if (r_state == ST_HALTED) begin
            w_instr_next = INSTR_NOP;
         end else if (i_jump) begin
            w_pc_next    = w_jump_target;
            w_instr_next = INSTR_NOP;
         end else if (!i_stall) begin
            w_instr_next = w_fetch;
            w_pc4_next   = w_pc_plus4;
            w_state_next = (w_fetch == INSTR_HALT) ? ST_HALTED : ST_RUN;
            w_pc_next    = (w_fetch == INSTR_HALT) ? r_pc : w_pc_plus4;
         end
      end
   end
   // PC and IF/ID pipeline registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc    <= '0;
         r_pc4   <= '0;
         r_instr <= INSTR_NOP;
      end else begin
         r_pc    <= w_pc_next;
         r_pc4   <= w_pc4_next;
         r_instr <= w_instr_next;
      end
   end
   assign o_pc          = r_pc;
   assign o_pc4         = r_pc4;
   assign o_instruction = r_instr;
   assign o_halt        = (r_state == ST_HALTED);
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch, stall, redirect, halt, enable and wrap
module tb_instruction_fetch;
   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1, i_enable = 1'b1, i_stall = 1'b0, i_jump = 1'b0, i_imem_we = 1'b0;
   logic [31:0] i_jump_addr = '0, i_imem_wdata = '0;
   logic [7:0]  i_imem_waddr = '0;
   logic [31:0] o_pc, o_pc4, o_instruction;
   logic        o_halt;
   int          n_checks = 0, n_fail = 0;

   instruction_fetch dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
      .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_imem_we(i_imem_we),
      .i_imem_waddr(i_imem_waddr), .i_imem_wdata(i_imem_wdata),
      .o_pc(o_pc), .o_pc4(o_pc4), .o_instruction(o_instruction), .o_halt(o_halt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      i_imem_we = 1'b1; i_imem_waddr = a; i_imem_wdata = d;
      tick();
      i_imem_we = 1'b0;
   endtask

   task automatic chk3(input string tag, input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] pc);
      check({tag, "_instr"}, o_instruction, instr);
      check({tag, "_pc4"}, o_pc4, pc4);
      check({tag, "_pc"}, o_pc, pc);
   endtask

   initial begin
      wr(8'd0, 32'h20010005);
      wr(8'd1, 32'h20020003);
      wr(8'd2, 32'h00221820);
      wr(8'd3, 32'h11111111);
      wr(8'd4, 32'h22222222);
      wr(8'd5, 32'h33333333);
      wr(8'd16, 32'hABCD0016);
      wr(8'd255, 32'hDEAD00FF);
      tick();
      chk3("reset", 32'h0, 32'h0, 32'h0);
      check("reset_halt", {31'b0, o_halt}, 32'd0);
      i_reset = 1'b0;
      tick(); chk3("f0", 32'h20010005, 32'd4, 32'd4);
      tick(); chk3("f1", 32'h20020003, 32'd8, 32'd8);
      tick(); chk3("f2", 32'h00221820, 32'd12, 32'd12);
      i_stall = 1'b1;
      tick(); chk3("stall1", 32'h00221820, 32'd12, 32'd12);
      tick(); chk3("stall2", 32'h00221820, 32'd12, 32'd12);
      i_stall = 1'b0;
      tick(); chk3("resume", 32'h11111111, 32'd16, 32'd16);
      i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'h00000043;
      tick(); chk3("jflush", 32'h0, 32'd16, 32'h40);
      i_stall = 1'b0; i_jump = 1'b0;
      tick(); chk3("jtarget", 32'hABCD0016, 32'h44, 32'h44);
      i_jump = 1'b1; i_jump_addr = 32'h000003FC;
      tick(); chk3("jlast", 32'h0, 32'h44, 32'h3FC);
      i_jump = 1'b0;
      tick(); chk3("last", 32'hDEAD00FF, 32'h400, 32'h400);
      tick(); chk3("wrap", 32'h20010005, 32'h404, 32'h404);
      i_reset = 1'b1;
      tick(); chk3("rst2", 32'h0, 32'h0, 32'h0);
      i_reset = 1'b0;
      tick(); tick(); chk3("pre_en", 32'h20020003, 32'd8, 32'd8);
      i_enable = 1'b0;
      wr(8'd5, 32'h12345678); chk3("frz1", 32'h20020003, 32'd8, 32'd8);
      tick(); chk3("frz2", 32'h20020003, 32'd8, 32'd8);
      tick(); chk3("frz3", 32'h20020003, 32'd8, 32'd8);
      i_enable = 1'b1;
      tick(); chk3("en2", 32'h00221820, 32'd12, 32'd12);
      tick(); tick(); chk3("en4", 32'h22222222, 32'd20, 32'd20);
      tick(); chk3("en5", 32'h12345678, 32'd24, 32'd24);
      i_reset = 1'b1;
      wr(8'd3, 32'hFFFFFFFF);
      i_reset = 1'b0;
      tick(); tick(); tick(); chk3("h2", 32'h00221820, 32'd12, 32'd12);
      tick(); chk3("halt", 32'hFFFFFFFF, 32'd16, 32'd12);
      check("halt_flag", {31'b0, o_halt}, 32'd1);
      i_jump = 1'b1; i_jump_addr = 32'h40;
      tick(); chk3("hjump", 32'h0, 32'd16, 32'd12);
      check("hjump_flag", {31'b0, o_halt}, 32'd1);
      i_jump = 1'b0;
      tick(); chk3("hhold", 32'h0, 32'd16, 32'd12);
      i_reset = 1'b1;
      tick(); check("hrst_pc", o_pc, 32'h0);
      check("hrst_flag", {31'b0, o_halt}, 32'd0);
      i_reset = 1'b0;
      tick(); chk3("intact", 32'h20010005, 32'd4, 32'd4);
      tick(); tick(); chk3("pre_jh", 32'h00221820, 32'd12, 32'd12);
      i_jump = 1'b1; i_jump_addr = 32'h10;
      tick(); chk3("jh", 32'h0, 32'd12, 32'h10);
      check("jh_flag", {31'b0, o_halt}, 32'd0);
      i_jump = 1'b0;
      i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'hC;
      tick(); i_jump = 1'b0;
      tick(); chk3("sh", 32'h0, 32'd12, 32'hC);
      check("sh_flag", {31'b0, o_halt}, 32'd0);
      i_stall = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
